// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO read-side output stage.
package fifo_pkg;

    localparam int DSIZE_DEF  = 8;
    localparam int BUF_DEPTH  = 2;
    localparam int MEM_RD_LAT = 1;

    typedef logic [1:0] occ_t;

    // Highest occupancy (after this cycle's pop) at which one more read may be issued.
    localparam occ_t CREDIT_MAX = occ_t'(BUF_DEPTH - MEM_RD_LAT);

    function automatic occ_t occ_sum(input occ_t count, input logic inflight);
        return count + {1'b0, inflight};
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying FIFO words out of the read domain.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) ();

    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/out_skid_buf.sv
// Two-entry ordered register buffer; head is entry 0, a same-cycle pop frees a slot for the write.
module out_skid_buf
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             pop,
    output occ_t             count,
    output logic [DSIZE-1:0] head
);

    logic [DSIZE-1:0] ent0_r, ent1_r, ent0_s, ent1_s;
    occ_t             count_r, count_s;

    // Next-state computation for entries and fill level.
    always_comb begin
        ent0_s  = ent0_r;
        ent1_s  = ent1_r;
        count_s = count_r;
        if (clr) begin
            count_s = 2'd0;
        end else begin
            case ({wr_en, pop && (count_r != 2'd0)})
                2'b10: begin
                    case (count_r)
                        2'd0: begin
                            ent0_s  = wr_data;
                            count_s = 2'd1;
                        end
                        2'd1: begin
                            ent1_s  = wr_data;
                            count_s = 2'd2;
                        end
                        default: count_s = count_r;
                    endcase
                end
                2'b01: begin
                    ent0_s  = ent1_r;
                    count_s = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        ent0_s = ent1_r;
                        ent1_s = wr_data;
                    end else begin
                        ent0_s = wr_data;
                    end
                end
                default: count_s = count_r;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_r  <= {DSIZE{1'b0}};
            ent1_r  <= {DSIZE{1'b0}};
            count_r <= 2'd0;
        end else begin
            ent0_r  <= ent0_s;
            ent1_r  <= ent1_s;
            count_r <= count_s;
        end
    end

    assign count = count_r;
    assign head  = ent0_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter: credit-based read issue, flush, delivered-word counter.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CNTW  = 16
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       mem_rdata,
    output logic                   rinc,
    fifo_rd_stream_if.master       strm,
    input  logic                   flush,
    output logic [CNTW-1:0]        word_cnt
);

    occ_t             count_s;
    occ_t             occ_s;
    logic [DSIZE-1:0] head_s;
    logic             inflight_r;
    logic             pop_s;
    logic             wr_en_s;
    logic [CNTW-1:0]  word_cnt_r;

    out_skid_buf #(.DSIZE(DSIZE)) u_buf (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .clr     (flush),
        .wr_en   (wr_en_s),
        .wr_data (mem_rdata),
        .pop     (pop_s),
        .count   (count_s),
        .head    (head_s)
    );

    assign strm.m_valid = (count_s != 2'd0);
    assign strm.m_data  = head_s;
    assign pop_s        = strm.m_valid & strm.m_ready;
    assign occ_s        = occ_sum(count_s, inflight_r);
    // Data landing during a flush cycle belongs to the discarded stream.
    assign wr_en_s      = inflight_r & ~flush;

    // Read issue: only when a slot is guaranteed for the returning word.
    always_comb begin
        rinc = 1'b0;
        if (rrst_n && !rempty && !flush && ((occ_s - {1'b0, pop_s}) <= CREDIT_MAX)) begin
            rinc = 1'b1;
        end else begin
            rinc = 1'b0;
        end
    end

    // In-flight read tracking; a flush cycle never issues, so this clears too.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rinc;
        end
    end

    // Saturating count of accepted words.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_cnt_r <= {CNTW{1'b0}};
        end else if (pop_s && (word_cnt_r != {CNTW{1'b1}})) begin
            word_cnt_r <= word_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a queue-based upstream FIFO and delivery model.
module tb_fifo_rd_stream;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rempty;
    logic [DW-1:0] mem_rdata;
    logic          rinc;
    logic          flush;
    logic [CW-1:0] word_cnt;

    fifo_rd_stream_if #(.DSIZE(DW)) strm ();

    fifo_rd_stream #(.DSIZE(DW), .CNTW(CW)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .mem_rdata (mem_rdata),
        .rinc      (rinc),
        .strm      (strm),
        .flush     (flush),
        .word_cnt  (word_cnt)
    );

    always #5 rclk = ~rclk;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] fifo_q[$];   // words still in the upstream FIFO
    logic [DW-1:0] exp_q[$];    // words read from the FIFO, awaiting delivery in order
    int            cnt_model;
    logic          inflight_m;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        rempty = 1'b0;
    endtask

    // One clock: observe rinc, then model the memory returning that word next cycle.
    task automatic step();
        logic          r;
        logic [DW-1:0] w;
        @(negedge rclk);
        r = rinc;
        @(posedge rclk);
        #1;
        if (flush) exp_q.delete();
        if (r && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            mem_rdata = w;
            exp_q.push_back(w);
        end else begin
            mem_rdata = DW'($urandom);
        end
        rempty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        flush = 1'b0;
        strm.m_ready = 1'b0;
        rempty = 1'b0;
        mem_rdata = '0;
        fifo_q.delete();
        exp_q.delete();
        #1;
        chk("rst_m_valid", int'(strm.m_valid), 0);
        chk("rst_m_data", int'(strm.m_data), 0);
        chk("rst_word_cnt", int'(word_cnt), 0);
        chk("rst_rinc", int'(rinc), 0);
        rempty = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    // Monitor: compares every cycle against the queue model and pops on each accepted word.
    initial begin
        int            pend;
        logic          pop;
        logic [DW-1:0] d;
        inflight_m = 1'b0;
        cnt_model  = 0;
        forever begin
            @(negedge rclk);
            if (!rrst_n) begin
                inflight_m = 1'b0;
                cnt_model  = 0;
            end else begin
                pend = exp_q.size();
                pop  = strm.m_valid & strm.m_ready;
                chk("m_valid", int'(strm.m_valid), int'((pend - int'(inflight_m)) > 0));
                chk("rinc", int'(rinc), int'(!rempty && !flush && ((pend - int'(pop)) < 2)));
                chk("word_cnt", int'(word_cnt), cnt_model);
                chk("outstanding_le2", int'(pend <= 2), 1);
                if (strm.m_valid && pend > 0) chk("m_data", int'(strm.m_data), int'(exp_q[0]));
                if (pop && pend > 0) begin
                    d = exp_q.pop_front();
                    if (cnt_model < CMAX) cnt_model++;
                end
                inflight_m = rinc;
            end
        end
    end

    initial begin
        do_reset();

        // single word, latency and return to idle
        strm.m_ready = 1'b1;
        push_word(8'h11);
        repeat (5) step();
        chk("basic_cnt", int'(word_cnt), 1);

        // back-to-back stream
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        repeat (12) step();
        chk("thru_cnt", int'(word_cnt), 9);

        // backpressure: only two reads outstanding
        strm.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(DW'(8'h20 + i));
        repeat (8) step();
        chk("bp_fifo_left", fifo_q.size(), 3);
        chk("bp_valid", int'(strm.m_valid), 1);
        chk("bp_head", int'(strm.m_data), 32);
        strm.m_ready = 1'b1;
        repeat (10) step();
        chk("bp_cnt", int'(word_cnt), 14);
        chk("bp_fifo_drained", fifo_q.size(), 0);

        // flush the cycle after a read issue
        strm.m_ready = 1'b0;
        push_word(8'h30);
        push_word(8'h31);
        push_word(8'h32);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_no_rinc", fifo_q.size(), 2);
        chk("flush_valid_low", int'(strm.m_valid), 0);
        strm.m_ready = 1'b1;
        repeat (8) step();
        chk("flush_cnt_sat", int'(word_cnt), 15);

        // saturation holds with further traffic
        for (int i = 0; i < 6; i++) push_word(DW'(8'h50 + i));
        repeat (10) step();
        chk("sat_cnt", int'(word_cnt), 15);

        // asynchronous reset with a full buffer
        strm.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(8'h40 + i));
        repeat (5) step();
        chk("pre_arst_valid", int'(strm.m_valid), 1);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("arst_valid", int'(strm.m_valid), 0);
        chk("arst_rinc", int'(rinc), 0);
        chk("arst_cnt", int'(word_cnt), 0);
        fifo_q.delete();
        exp_q.delete();
        rempty = 1'b1;
        flush = 1'b0;
        @(posedge rclk);
        #1;
        rrst_n = 1'b1;

        // randomized traffic, backpressure and flushes
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 1) == 1) push_word(DW'($urandom));
            strm.m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        strm.m_ready = 1'b1;
        repeat (1600) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0) break;
            step();
        end
        repeat (3) step();
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_fifo", fifo_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
